// File: rtl/hdlc_line_monitor.sv
// HDLC line monitor: decodes flag/abort/idle/stuffed-zero patterns on a sampled serial line,
// delimits frames, checks alignment and length limits, and keeps saturating frame statistics.
module hdlc_line_monitor #(
   parameter int MAX_BYTES = 128,
   parameter int MIN_BYTES = 4,
   parameter int IDLE_LEN  = 8,
   parameter int CNT_W     = 16
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic                           BitEn,
   input  logic                           Line,
   input  logic                           Clear,
   output logic                           FlagDet,
   output logic                           AbortDet,
   output logic                           ZeroRemoved,
   output logic                           IdleDet,
   output logic                           InFrame,
   output logic                           FrameDone,
   output logic                           FrameErr,
   output logic                           FrameAborted,
   output logic                           FrameOverflow,
   output logic [$clog2(MAX_BYTES+1)-1:0] FrameBytes,
   output logic [CNT_W-1:0]               FrameCnt,
   output logic [CNT_W-1:0]               AbortCnt,
   output logic [CNT_W-1:0]               ErrCnt
);
   localparam int BYTES_W   = $clog2(MAX_BYTES+1);
   localparam int BIT_LIMIT = 8*(MAX_BYTES+1)+7;
   localparam int BIT_W     = $clog2(BIT_LIMIT+1);
   localparam int ONES_W    = $clog2(IDLE_LEN+1);

   localparam logic [BIT_W-1:0]  PREFIX_BITS = BIT_W'(7);
   localparam logic [BIT_W-1:0]  MIN_BITS    = BIT_W'(8*MIN_BYTES);
   localparam logic [BIT_W-1:0]  LIMIT_BITS  = BIT_W'(BIT_LIMIT);
   localparam logic [ONES_W-1:0] IDLE_ONES   = ONES_W'(IDLE_LEN);

   typedef enum logic [1:0] {HUNT, OPEN, FRAME} state_t;

   state_t            state, stateNext;
   logic [1:0]        rstSync;
   logic              rstInt;
   logic [ONES_W-1:0] ones, onesNext;
   logic              seenZero;
   logic [BIT_W-1:0]  bitCnt, bitCntNext, bitCntInc, frameBits;
   logic              isZero, isStuff, isFlag, isAbort;
   logic              doneNext, errNext, abortedNext, ovfNext;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) rstSync <= 2'b00;
      else      rstSync <= {rstSync[0], 1'b1};
   end
   assign rstInt = rstSync[1];

   assign isZero    = BitEn && !Line;
   assign isStuff   = isZero && (ones == ONES_W'(5));
   assign isFlag    = isZero && (ones == ONES_W'(6)) && seenZero;
   assign isAbort   = BitEn && Line && (ones == ONES_W'(6));
   assign bitCntInc = bitCnt + BIT_W'(1);
   assign frameBits = bitCnt - PREFIX_BITS;

   always_comb begin
      onesNext = ones;
      if (BitEn) begin
         if (!Line)                  onesNext = '0;
         else if (ones != IDLE_ONES) onesNext = ones + ONES_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge rstInt) begin
      if (!rstInt) state <= HUNT;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      bitCntNext  = bitCnt;
      doneNext    = 1'b0;
      errNext     = 1'b0;
      abortedNext = 1'b0;
      ovfNext     = 1'b0;
      if (isFlag) begin
         stateNext  = OPEN;
         bitCntNext = '0;
         if (state == FRAME && bitCnt > PREFIX_BITS) begin
            doneNext = 1'b1;
            errNext  = (frameBits[2:0] != 3'd0) || (frameBits < MIN_BITS);
         end
      end else if (isAbort) begin
         abortedNext = (state == FRAME);
         stateNext   = HUNT;
         bitCntNext  = '0;
      end else if (BitEn && !isStuff && state != HUNT) begin
         bitCntNext = bitCntInc;
         // Content is only certain once more bits follow the flag than any flag prefix can hold.
         if (state == OPEN && bitCntInc > PREFIX_BITS) begin
            stateNext = FRAME;
         end else if (state == FRAME && bitCntInc == LIMIT_BITS) begin
            ovfNext    = 1'b1;
            stateNext  = HUNT;
            bitCntNext = '0;
         end
      end
   end

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge Clk or negedge rstInt) begin
      if (!rstInt) begin
         ones          <= '0;
         seenZero      <= 1'b0;
         bitCnt        <= '0;
         FlagDet       <= 1'b0;
         AbortDet      <= 1'b0;
         ZeroRemoved   <= 1'b0;
         IdleDet       <= 1'b0;
         InFrame       <= 1'b0;
         FrameDone     <= 1'b0;
         FrameErr      <= 1'b0;
         FrameAborted  <= 1'b0;
         FrameOverflow <= 1'b0;
         FrameBytes    <= '0;
         FrameCnt      <= '0;
         AbortCnt      <= '0;
         ErrCnt        <= '0;
      end else begin
         ones          <= onesNext;
         seenZero      <= seenZero | isZero;
         bitCnt        <= bitCntNext;
         FlagDet       <= isFlag;
         AbortDet      <= isAbort;
         ZeroRemoved   <= isStuff;
         IdleDet       <= (onesNext >= IDLE_ONES);
         InFrame       <= (stateNext == FRAME);
         FrameDone     <= doneNext;
         FrameErr      <= errNext;
         FrameAborted  <= abortedNext;
         FrameOverflow <= ovfNext;
         if (doneNext) FrameBytes <= BYTES_W'(frameBits >> 3);
         if (Clear) begin
            FrameCnt <= '0;
            AbortCnt <= '0;
            ErrCnt   <= '0;
         end else begin
            if (doneNext && !errNext)           FrameCnt <= satInc(FrameCnt);
            if (abortedNext)                    AbortCnt <= satInc(AbortCnt);
            if ((doneNext && errNext) || ovfNext) ErrCnt <= satInc(ErrCnt);
         end
      end
   end
endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Bench for hdlc_line_monitor: directed scenarios plus random traffic, every cycle scored
// against a frame-level reference model through an expectation queue.
module tb_hdlc_line_monitor;
   localparam int MAX_BYTES = 128;
   localparam int MIN_BYTES = 4;
   localparam int IDLE_LEN  = 8;
   localparam int CNT_W     = 16;
   localparam int LIMIT     = 8*(MAX_BYTES+1)+7;

   logic Clk = 1'b0, Rst = 1'b0, BitEn = 1'b0, Line = 1'b0, Clear = 1'b0;
   logic FlagDet, AbortDet, ZeroRemoved, IdleDet, InFrame;
   logic FrameDone, FrameErr, FrameAborted, FrameOverflow;
   logic [7:0]       FrameBytes;
   logic [CNT_W-1:0] FrameCnt, AbortCnt, ErrCnt;

   typedef struct packed {
      logic flag, abort, zero, idle, inFrame, done, err, aborted, ovf;
      logic [7:0]  bytes;
      logic [15:0] fcnt, acnt, ecnt;
   } obs_t;

   obs_t expQ[$];
   obs_t m;
   int   mOnes;
   bit   mSeenZero, mSynced;
   bit   fq[$];              // destuffed bits since the last flag, only while synchronised
   int   run;
   int   vectors = 0, miscompares = 0;

   hdlc_line_monitor #(.MAX_BYTES(MAX_BYTES), .MIN_BYTES(MIN_BYTES), .IDLE_LEN(IDLE_LEN), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst(Rst), .BitEn(BitEn), .Line(Line), .Clear(Clear),
      .FlagDet(FlagDet), .AbortDet(AbortDet), .ZeroRemoved(ZeroRemoved), .IdleDet(IdleDet),
      .InFrame(InFrame), .FrameDone(FrameDone), .FrameErr(FrameErr), .FrameAborted(FrameAborted),
      .FrameOverflow(FrameOverflow), .FrameBytes(FrameBytes),
      .FrameCnt(FrameCnt), .AbortCnt(AbortCnt), .ErrCnt(ErrCnt));

   always #5 Clk = ~Clk;

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic modelReset();
      m = '0; mOnes = 0; mSeenZero = 0; mSynced = 0; fq.delete();
   endtask

   task automatic pushData(input bit b, input bit wasFrame);
      fq.push_back(b);
      if (wasFrame && fq.size() == LIMIT) begin
         m.ovf = 1; m.ecnt = sat(m.ecnt); mSynced = 0; fq.delete();
      end
   endtask

   task automatic modelStep(input bit en, input bit b, input bit clr);
      bit wasFrame;
      int n;
      {m.flag, m.abort, m.zero, m.done, m.err, m.aborted, m.ovf} = '0;
      if (en) begin
         wasFrame = mSynced && fq.size() >= 8;
         if (b) begin
            if (mOnes == 6) begin
               m.abort = 1;
               if (wasFrame) begin m.aborted = 1; m.acnt = sat(m.acnt); end
               mSynced = 0; fq.delete();
            end else if (mSynced) pushData(1'b1, wasFrame);
            mOnes = (mOnes < IDLE_LEN) ? mOnes + 1 : IDLE_LEN;
         end else begin
            if (mOnes == 5) m.zero = 1;
            else if (mOnes == 6 && mSeenZero) begin
               m.flag = 1;
               if (wasFrame) begin
                  n = fq.size() - 7;
                  m.done = 1; m.bytes = 8'(n / 8);
                  m.err = (n % 8 != 0) || (n / 8 < MIN_BYTES);
                  if (m.err) m.ecnt = sat(m.ecnt);
                  else       m.fcnt = sat(m.fcnt);
               end
               mSynced = 1; fq.delete();
            end else if (mSynced) pushData(1'b0, wasFrame);
            mOnes = 0; mSeenZero = 1;
         end
         m.idle    = (mOnes >= IDLE_LEN);
         m.inFrame = mSynced && fq.size() >= 8;
      end
      if (clr) begin m.fcnt = '0; m.acnt = '0; m.ecnt = '0; end
   endtask

   task automatic drive(input bit en, input bit b, input bit clr);
      @(negedge Clk);
      BitEn = en; Line = b; Clear = clr;
      modelStep(en, b, clr);
      expQ.push_back(m);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic sendBit(input bit b, input bit clr);
      if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
      drive(1'b1, b, clr);
   endtask

   task automatic sendData(input bit b);
      sendBit(b, 1'b0);
      run = b ? run + 1 : 0;
      if (run == 5) begin sendBit(1'b0, 1'b0); run = 0; end
   endtask

   task automatic sendByte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) sendData(v[i]);
   endtask

   task automatic sendFlag(input bit clrLast);
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 0; i < 8; i++) sendBit(f[i], clrLast && (i == 7));
      run = 0;
   endtask

   task automatic sendOnes(input int n);
      repeat (n) sendBit(1'b1, 1'b0);
      run = 0;
   endtask

   task automatic resetPulse(input int n);
      @(negedge Clk);
      Rst = 1'b0; BitEn = 1'b0; Line = 1'b0; Clear = 1'b0;
      modelReset(); expQ.push_back(m);
      repeat (n - 1) begin @(negedge Clk); expQ.push_back(m); end
      @(negedge Clk);
      Rst = 1'b1; expQ.push_back(m);
      idle(3);
   endtask

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Output monitor: one expectation per driven cycle, compared after the edge settles.
   initial begin
      obs_t e, got;
      forever begin
         @(posedge Clk); #2;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            got = {FlagDet, AbortDet, ZeroRemoved, IdleDet, InFrame, FrameDone, FrameErr,
                   FrameAborted, FrameOverflow, FrameBytes, FrameCnt, AbortCnt, ErrCnt};
            vectors++;
            if (got !== e) begin
               miscompares++;
               if (miscompares <= 20)
                  $display("FAIL cycle_vector @%0t: got %h expected %h", $time, got, e);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [14:0] sz;
      int k;
      modelReset();
      run = 0;
      resetPulse(3);

      // Idle, opening flag, aligned 4-byte frame
      sendOnes(8);
      sendFlag(1'b0);
      sendByte(8'h12); sendByte(8'h34); sendByte(8'h56); sendByte(8'h78);
      sendFlag(1'b0);
      idle(2);
      check("t1_frame_cnt", FrameCnt, 1);
      check("t1_frame_bytes", FrameBytes, 4);
      check("t1_err_cnt", ErrCnt, 0);

      // 0xFF needs a stuffed zero
      sendByte(8'hFF); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
      sendFlag(1'b0);
      idle(2);
      check("t2_frame_cnt", FrameCnt, 2);
      check("t2_frame_bytes", FrameBytes, 4);

      // Abort mid-frame
      repeat (20) sendData(1'($urandom));
      sendOnes(7);
      idle(2);
      check("t3_abort_cnt", AbortCnt, 1);
      check("t3_in_frame", InFrame, 0);

      // Overflow, then a maximum-length frame
      sendFlag(1'b0);
      repeat (129) sendByte(8'($urandom));
      sendFlag(1'b0);
      idle(2);
      check("t4_err_cnt", ErrCnt, 1);
      check("t4_frame_cnt", FrameCnt, 2);
      repeat (128) sendByte(8'($urandom));
      sendFlag(1'b0);
      idle(2);
      check("t4_max_frame_cnt", FrameCnt, 3);
      check("t4_max_bytes", FrameBytes, 128);

      // Misaligned and short frames
      repeat (35) sendData(1'($urandom));
      sendFlag(1'b0);
      idle(2);
      check("t5_misaligned_err", ErrCnt, 2);
      check("t5_misaligned_bytes", FrameBytes, 4);
      repeat (3) sendByte(8'($urandom));
      sendFlag(1'b0);
      idle(2);
      check("t5_short_err", ErrCnt, 3);
      check("t5_short_bytes", FrameBytes, 3);

      // Idle detection, then shared-zero flags
      sendOnes(8);
      idle(2);
      check("t6_idle", IdleDet, 1);
      sz = 15'b011111101111110;
      for (int i = 14; i >= 0; i--) sendBit(sz[i], 1'b0);
      run = 0;
      idle(2);
      check("t6_shared_in_frame", InFrame, 0);
      check("t6_shared_frame_cnt", FrameCnt, 3);

      // Clear on the frame-closing bit
      repeat (4) sendByte(8'($urandom));
      sendFlag(1'b1);
      idle(2);
      check("t6_clear_frame_cnt", FrameCnt, 0);
      check("t6_clear_err_cnt", ErrCnt, 0);
      check("t6_clear_abort_cnt", AbortCnt, 0);

      // Reset mid-frame
      repeat (3) sendByte(8'($urandom));
      idle(2);
      check("t6_mid_in_frame", InFrame, 1);
      resetPulse(2);
      check("t6_rst_in_frame", InFrame, 0);
      check("t6_rst_bytes", FrameBytes, 0);

      // Random traffic
      sendOnes(8);
      sendFlag(1'b0);
      for (int it = 0; it < 60; it++) begin
         k = $urandom_range(9);
         if (k <= 5) begin
            repeat ($urandom_range(8)) sendByte(8'($urandom));
            sendFlag(1'b0);
         end else if (k == 6) begin
            repeat ($urandom_range(40)) sendData(1'($urandom));
            sendFlag(1'b0);
         end else if (k == 7) begin
            sendOnes($urandom_range(12, 7));
            sendFlag(1'b0);
         end else if (k == 8) begin
            drive(1'b0, 1'b0, 1'b1);
         end else begin
            repeat ($urandom_range(20, 1)) sendBit(1'($urandom), 1'b0);
            run = 0;
         end
      end

      idle(3);
      @(posedge Clk); #3;
      check("queue_drained", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
